// File: rtl/pipe_skid_slice_pkg.sv
// Shared definitions for the pipe skid slice.
//   slice_state_t : occupancy state of the two-entry slice
//   PIPE_DATA_W   : payload width of the pipe datapath
package pipe_pkg;

  localparam int unsigned PIPE_DATA_W = 3;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,  // main invalid
    BUSY  = 2'd1,  // main valid, skid empty
    FULL  = 2'd2   // main and skid valid
  } slice_state_t;

endpackage

// File: rtl/pipe_skid_slice_if.sv
// Valid/ready beat channel.
//   valid : beat present (master -> slave)
//   data  : payload      (master -> slave)
//   ready : slave accepts (slave -> master)
interface pipe_skid_slice_if #(
  parameter int unsigned DATA_W = pipe_pkg::PIPE_DATA_W
);
  logic              valid;
  logic [DATA_W-1:0] data;
  logic              ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_skid_slice_evt_cnt.sv
// Event counter with synchronous clear.
//   i_clk : clock, rising edge
//   i_clr : synchronous clear, active-high
//   i_inc : count one event this cycle
//   o_cnt : current count; wraps (SAT=0) or holds at all-ones (SAT=1)
module pipe_evt_cnt #(
  parameter int unsigned CNT_W = 16,
  parameter bit          SAT   = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      if (!(SAT && (r_cnt == '1))) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/pipe_skid_slice.sv
// Registered two-entry valid/ready slice with beat and stall counters.
//   sys_clk   : clock, rising edge
//   sys_rst   : synchronous reset, active-high
//   up        : upstream channel (valid/data in, ready out from a flop)
//   down      : downstream channel (valid/data out from flops, ready in)
//   occ       : entries held (0, 1, 2)
//   beat_cnt  : beats delivered downstream, wrapping
//   stall_cnt : cycles with valid and no ready downstream, saturating
module pipe_skid_slice
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = PIPE_DATA_W,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  pipe_skid_slice_if.slave     up,
  pipe_skid_slice_if.master    down,
  output logic [1:0]           occ,
  output logic [CNT_W-1:0]     beat_cnt,
  output logic [CNT_W-1:0]     stall_cnt
);
  slice_state_t      r_state, w_next;
  logic [DATA_W-1:0] r_main, r_skid;
  logic              r_ready;
  logic              w_up_fire, w_dn_fire, w_valid;
  logic              w_main_from_up, w_main_from_skid, w_skid_from_up;

  assign w_valid   = (r_state != EMPTY);
  assign w_up_fire = up.valid & r_ready;
  assign w_dn_fire = w_valid & down.ready;

  always_comb begin
    w_next           = r_state;
    w_main_from_up   = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_from_up   = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_up_fire) begin
          w_main_from_up = 1'b1;
          w_next         = BUSY;
        end
      end
      BUSY: begin
        if (w_up_fire && w_dn_fire) begin
          w_main_from_up = 1'b1;
        end else if (w_up_fire) begin
          w_skid_from_up = 1'b1;
          w_next         = FULL;
        end else if (w_dn_fire) begin
          w_next = EMPTY;
        end
      end
      FULL: begin
        // ready_up is low here, so no upstream beat can arrive
        if (w_dn_fire) begin
          w_main_from_skid = 1'b1;
          w_next           = BUSY;
        end
      end
      default: w_next = EMPTY;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state <= EMPTY;
      r_ready <= 1'b0;
      r_main  <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_next;
      // ready computed from next state keeps the ready path registered
      r_ready <= (w_next != FULL);
      if (w_main_from_up) r_main <= up.data;
      else if (w_main_from_skid) r_main <= r_skid;
      if (w_skid_from_up) r_skid <= up.data;
    end
  end

  assign up.ready   = r_ready;
  assign down.valid = w_valid;
  assign down.data  = r_main;

  always_comb begin
    case (r_state)
      BUSY:    occ = 2'd1;
      FULL:    occ = 2'd2;
      default: occ = 2'd0;
    endcase
  end

  pipe_evt_cnt #(.CNT_W(CNT_W), .SAT(1'b0)) u_beat_cnt (
    .i_clk (sys_clk),
    .i_clr (sys_rst),
    .i_inc (w_dn_fire),
    .o_cnt (beat_cnt)
  );

  pipe_evt_cnt #(.CNT_W(CNT_W), .SAT(1'b1)) u_stall_cnt (
    .i_clk (sys_clk),
    .i_clr (sys_rst),
    .i_inc (w_valid & ~down.ready),
    .o_cnt (stall_cnt)
  );
endmodule

// File: tb/tb_pipe_skid_slice.sv
// Self-checking bench for pipe_skid_slice: scoreboard of accepted beats
// compared against every downstream beat, plus directed scenario checks.
module tb_pipe_skid_slice;
  localparam int unsigned DW = 3;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    occ;
  logic [CW-1:0] beat_cnt, stall_cnt;

  pipe_skid_slice_if #(.DATA_W(DW)) up_if ();
  pipe_skid_slice_if #(.DATA_W(DW)) dn_if ();

  pipe_skid_slice #(.DATA_W(DW), .CNT_W(CW)) dut (
    .sys_clk   (clk),
    .sys_rst   (rst),
    .up        (up_if),
    .down      (dn_if),
    .occ       (occ),
    .beat_cnt  (beat_cnt),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // scoreboard model
  logic [DW-1:0] q[$];
  int            m_beat   = 0;
  int            m_stall  = 0;
  bit            m_rstp   = 1'b1;  // sys_rst as sampled at the last edge
  int            max_occ  = 0;

  always @(negedge clk) begin
    if ($time > 0) begin
      check("occ", 32'(occ), 32'(q.size()));
      check("valid_down", 32'(dn_if.valid), 32'(q.size() != 0));
      check("ready_up", 32'(up_if.ready), 32'(!m_rstp && q.size() < 2));
      if (q.size() != 0) check("data_down", 32'(dn_if.data), 32'(q[0]));
      if (m_rstp) check("data_rst", 32'(dn_if.data), 32'd0);
      check("beat_cnt", 32'(beat_cnt), 32'(m_beat));
      check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
      if (int'(occ) > max_occ) max_occ = int'(occ);
      if (rst) begin
        q.delete();
        m_beat  = 0;
        m_stall = 0;
      end else begin
        if ((q.size() != 0) && dn_if.ready) begin
          void'(q.pop_front());
          m_beat = (m_beat + 1) % (1 << CW);
        end
        if ((q.size() != 0 || dn_if.valid) && !dn_if.ready && q.size() != 0)
          if (m_stall < (1 << CW) - 1) m_stall++;
        if (up_if.valid && up_if.ready) q.push_back(up_if.data);
      end
      m_rstp = rst;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // present one beat and hold it until accepted; leaves valid asserted
  task automatic send(input logic [DW-1:0] d);
    bit acc = 1'b0;
    up_if.valid = 1'b1;
    up_if.data  = d;
    for (int i = 0; i < 64 && !acc; i++) begin
      @(negedge clk);
      acc = up_if.ready;
      tick();
    end
    if (!acc) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    up_if.valid = 1'b0;
    for (int i = 0; i < cycles; i++) tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] d3 [4];
    bit acc;
    d3[0] = 3'd3; d3[1] = 3'd5; d3[2] = 3'd7; d3[3] = 3'd1;
    up_if.valid = 1'b0;
    up_if.data  = '0;
    dn_if.ready = 1'b0;

    // 1. reset
    do_reset(3);
    check("rst_ready", 32'(up_if.ready), 32'd0);
    check("rst_valid", 32'(dn_if.valid), 32'd0);
    tick();
    check("ready_after_rst", 32'(up_if.ready), 32'd1);

    // 2. streaming
    dn_if.ready = 1'b1;
    max_occ = 0;
    for (int i = 0; i < 4; i++) send(d3[i]);
    up_if.valid = 1'b0;
    repeat (3) tick();
    check("stream_max_occ", 32'(max_occ), 32'd1);
    check("stream_beats", 32'(beat_cnt), 32'd4);

    // 3. backpressure fill
    dn_if.ready = 1'b0;
    send(3'd2);
    send(3'd6);
    up_if.valid = 1'b0;
    check("bp_occ", 32'(occ), 32'd2);
    check("bp_ready", 32'(up_if.ready), 32'd0);
    check("bp_data", 32'(dn_if.data), 32'd2);
    repeat (3) tick();
    check("bp_hold", 32'(dn_if.data), 32'd2);
    dn_if.ready = 1'b1;
    repeat (3) tick();
    check("bp_drain_occ", 32'(occ), 32'd0);
    check("bp_drain_ready", 32'(up_if.ready), 32'd1);

    // 4. simultaneous accept and deliver
    dn_if.ready = 1'b0;
    send(3'd4);
    up_if.data  = 3'd5;
    dn_if.ready = 1'b1;
    tick();
    up_if.valid = 1'b0;
    check("sim_data", 32'(dn_if.data), 32'd5);
    check("sim_occ", 32'(occ), 32'd1);
    repeat (2) tick();

    // 5. reset mid-operation
    dn_if.ready = 1'b0;
    send(3'd1);
    send(3'd2);
    up_if.valid = 1'b0;
    check("mid_occ_full", 32'(occ), 32'd2);
    do_reset(1);
    check("mid_valid", 32'(dn_if.valid), 32'd0);
    check("mid_occ", 32'(occ), 32'd0);
    check("mid_beat", 32'(beat_cnt), 32'd0);
    check("mid_stall", 32'(stall_cnt), 32'd0);
    dn_if.ready = 1'b1;
    repeat (5) tick();

    // 6. counter wrap and saturation
    do_reset(1);
    tick();
    for (int i = 0; i < 17; i++) send(3'(i));
    up_if.valid = 1'b0;
    repeat (3) tick();
    check("beat_wrap", 32'(beat_cnt), 32'd1);
    dn_if.ready = 1'b0;
    send(3'd7);
    up_if.valid = 1'b0;
    repeat (20) tick();
    check("stall_sat", 32'(stall_cnt), 32'd15);
    dn_if.ready = 1'b1;
    repeat (3) tick();

    // random traffic, upstream holds each beat until accepted
    acc = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (!up_if.valid || acc) begin
        up_if.valid = 1'($urandom_range(0, 1));
        up_if.data  = DW'($urandom);
      end
      dn_if.ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = up_if.valid & up_if.ready;
      tick();
    end
    up_if.valid = 1'b0;
    dn_if.ready = 1'b1;
    repeat (4) tick();
    check("final_empty", 32'(occ), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
